// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO pair.
// Shift-add multiply and restoring divide, one bit per cycle, fixed latency.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic               prep_signed;
  logic               prep_div0;
  logic [2*WIDTH-1:0] prod_res;

  // Multiply keeps the multiplier in b_q and shifts the product right through acc;
  // divide shifts the dividend out of a_q into the partial remainder in acc's upper half.
  always_comb begin
    mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
    div_trial   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    div_diff    = div_trial - {1'b0, b_q};
    div_ge      = (div_trial >= {1'b0, b_q});
    prep_signed = op_q[0];
    prep_div0   = op_q[1] & (b_q == '0);
    prod_res    = neg_res_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (we_hi) hi_d = wd;
        if (we_lo) lo_d = wd;
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = PREP;
        end
      end
      PREP: begin
        // A zero divisor keeps the raw dividend so the unsigned datapath returns hi = a, lo = ~0.
        a_d       = (prep_signed && a_q[WIDTH-1] && !prep_div0) ? -a_q : a_q;
        b_d       = (prep_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        neg_res_d = prep_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem_d = prep_signed & op_q[1] & a_q[WIDTH-1];
        div0_d    = prep_div0;
        acc_d     = '0;
        cnt_d     = '0;
        state_d   = RUN;
      end
      RUN: begin
        if (op_q[1]) begin
          acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
          a_d   = a_q << 1;
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          if (div0_q) begin
            hi_d = acc_q[2*WIDTH-1:WIDTH];
            lo_d = acc_q[WIDTH-1:0];
          end else begin
            hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          end
        end else begin
          hi_d = prod_res[2*WIDTH-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign stall_req = busy & (start | rd_hilo | we_hi | we_lo);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: table of operations plus hand sequences
// for stalls, MTHI/MTLO, start-with-write and reset mid-operation.
module tb_muldiv_seq;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          rd_hilo;
  logic          we_hi;
  logic          we_lo;
  logic [W-1:0]  wd;
  logic          busy;
  logic          done;
  logic          stall_req;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .rd_hilo(rd_hilo), .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
    .busy(busy), .done(done), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] o, input logic [31:0] av,
                               input logic [31:0] bv, input logic rdh, input logic wh,
                               input logic wl, input logic [31:0] wdv);
    start   = st;
    op      = o;
    a       = av;
    b       = bv;
    rd_hilo = rdh;
    we_hi   = wh;
    we_lo   = wl;
    wd      = wdv;
  endtask

  // Issue one op and watch 40 cycles; n counts cycles after the issuing edge.
  task automatic runOp(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] rh, output logic [31:0] rl,
                       output int lat, output int ndone, output int nbusy);
    lat = -1; ndone = 0; nbusy = 0; rh = '0; rl = '0;
    @(negedge clk);
    applyStimulus(1'b1, o, av, bv, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = n;
          rh  = hi;
          rl  = lo;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rh, rl, h2, l2;
    int lat, ndone, nbusy, bad, lat2;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7"};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
    vecs[3]  = '{2'b10, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF, "divu_by0"};
    vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
    vecs[5]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100d7"};
    vecs[6]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_by0_neg"};
    vecs[7]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minsq"};
    vecs[8]  = '{2'b01, 32'd5,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFE2, "mult_5xm6"};
    vecs[9]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2"};
    vecs[10] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu_shift"};
    vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, "divu_maxd10"};
    vecs[12] = '{2'b11, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, "div_m100dm7"};
    vecs[13] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1xm1"};

    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset stall_req", 64'(stall_req), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, lat, ndone, nbusy);
      checkOutput({vecs[i].name, " hi"}, 64'(rh), 64'(vecs[i].exp_hi));
      checkOutput({vecs[i].name, " lo"}, 64'(rl), 64'(vecs[i].exp_lo));
      checkOutput({vecs[i].name, " latency"}, 64'(lat), 64'd35);
      checkOutput({vecs[i].name, " done pulses"}, 64'(ndone), 64'd1);
      checkOutput({vecs[i].name, " busy cycles"}, 64'(nbusy), 64'd34);
    end

    // Stall: DIVU 100/7, then rd_hilo and a second start from cycle k+5 on.
    bad = 0;
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      if (n < 5) applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      else       applyStimulus(1'b1, 2'b00, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      if (stall_req !== (n >= 5)) bad++;
      if (hi !== vecs[NV-1].exp_hi || lo !== vecs[NV-1].exp_lo) bad++;
      if (done !== 1'b0 || busy !== 1'b1) bad++;
    end
    checkOutput("stall window bad cycles", 64'(bad), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("stall done-cycle stall_req", 64'(stall_req), 64'd0);
    checkOutput("stall done-cycle done", 64'(done), 64'd1);
    checkOutput("stall done-cycle hi", 64'(hi), 64'd2);
    checkOutput("stall done-cycle lo", 64'(lo), 64'd14);
    lat2 = -1; h2 = '0; l2 = '0;
    for (int n = 36; n <= 80; n++) begin
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      if (n == 36) checkOutput("second op accepted busy", 64'(busy), 64'd1);
      if (done && lat2 < 0) begin
        lat2 = n;
        h2   = hi;
        l2   = lo;
      end
    end
    checkOutput("second op latency", 64'(lat2), 64'd70);
    checkOutput("second op hi", 64'(h2), 64'd0);
    checkOutput("second op lo", 64'(l2), 64'd12);

    // MTLO while busy is held off; lo keeps the previous result.
    lat = -1; rh = '0; rl = '0;
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 3) applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234);
      else        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      if (n == 3) checkOutput("mtlo busy stall_req", 64'(stall_req), 64'd1);
      if (n == 4) checkOutput("mtlo busy lo unchanged", 64'(lo), 64'd12);
      if (done && lat < 0) begin
        lat = n;
        rl  = lo;
      end
    end
    checkOutput("multu 9x9 lo", 64'(rl), 64'd81);

    // MTLO / MTHI in IDLE.
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234);
    #1;
    checkOutput("mtlo idle stall_req", 64'(stall_req), 64'd0);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("mtlo idle lo", 64'(lo), 64'h1234);
    checkOutput("mtlo idle hi unchanged", 64'(hi), 64'd0);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hABCD);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("mthi idle hi", 64'(hi), 64'hABCD);
    checkOutput("mthi idle lo unchanged", 64'(lo), 64'h1234);

    // start together with MTHI: write lands, op still runs and overwrites HI/LO.
    lat = -1; rh = '0; rl = '0;
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 32'd5, 32'd6, 1'b0, 1'b1, 1'b0, 32'h55);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      if (n == 1) begin
        checkOutput("start+mthi hi written", 64'(hi), 64'h55);
        checkOutput("start+mthi busy", 64'(busy), 64'd1);
      end
      if (done && lat < 0) begin
        lat = n;
        rh  = hi;
        rl  = lo;
      end
    end
    checkOutput("start+mthi result hi", 64'(rh), 64'd0);
    checkOutput("start+mthi result lo", 64'(rl), 64'd30);
    checkOutput("start+mthi latency", 64'(lat), 64'd35);

    // Reset at cycle k+20 of MULT 5x6.
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      if (n == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midop reset busy", 64'(busy), 64'd0);
    checkOutput("midop reset hi", 64'(hi), 64'd0);
    checkOutput("midop reset lo", 64'(lo), 64'd0);
    checkOutput("midop reset done", 64'(done), 64'd0);
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (done) ndone++;
    end
    checkOutput("midop reset no done", 64'(ndone), 64'd0);
    runOp(2'b00, 32'd5, 32'd6, rh, rl, lat, ndone, nbusy);
    checkOutput("post-reset multu lo", 64'(rl), 64'd30);
    checkOutput("post-reset multu hi", 64'(rh), 64'd0);
    checkOutput("post-reset multu latency", 64'(lat), 64'd35);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
